// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: major opcodes, immediate formats, default datapath width.
package riscv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

endpackage

// File: rtl/reg_file_bp.sv
// Architectural register file with x0 hardwired to zero and same-cycle write-through on both read ports.
module reg_file_bp #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    localparam int RW     = $clog2(REG_NUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [RW-1:0]   rd_addr1,
    input  logic [RW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2
);

    logic [XLEN-1:0] regs [REG_NUM];
    logic            wr_en;

    assign wr_en = we && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A write landing this cycle is forwarded so ID never sees a stale value.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        if (wr_en && (rd_addr1 == wr_addr)) rd_data1 = wr_data;
        if (wr_en && (rd_addr2 == wr_addr)) rd_data2 = wr_data;
        if (rd_addr1 == '0) rd_data1 = '0;
        if (rd_addr2 == '0) rd_data2 = '0;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage owning the ID/EX pipeline register, load-use hazard detection and stall/flush control.
module id_stage_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int REG_NUM = 32,
    parameter int HAZ_EN  = 1,
    localparam int RW     = $clog2(REG_NUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid_i,
    input  logic [31:0]     instr_id_i,
    input  logic [XLEN-1:0] pc_id_i,
    input  logic            flush_i,
    input  logic            ex_stall_i,
    output logic            stall_o,
    input  logic            RegWrite_id_i,
    input  logic [RW-1:0]   Wr_rd_id_i,
    input  logic [XLEN-1:0] Wr_reg_data_id_i,
    output logic            valid_ex_o,
    output logic [XLEN-1:0] pc_ex_o,
    output logic [6:0]      opcode_ex_o,
    output logic [2:0]      func3_ex_o,
    output logic            func7_ex_o,
    output logic [XLEN-1:0] imme_ex_o,
    output logic [XLEN-1:0] Rd_data1_ex_o,
    output logic [XLEN-1:0] Rd_data2_ex_o,
    output logic [RW-1:0]   Rs1_ex_o,
    output logic [RW-1:0]   Rs2_ex_o,
    output logic [RW-1:0]   Rd_ex_o,
    output logic            mem_read_ex_o,
    output logic            reg_write_ex_o
);

    logic [6:0]             opcode;
    logic [RW-1:0]          rd, rs1, rs2;
    logic [XLEN-1:0]        rs1_data, rs2_data;
    imm_type_e              imm_sel;
    logic signed [XLEN-1:0] imm;
    logic                   rs1_used, rs2_used;
    logic                   mem_read, reg_write;
    logic                   hazard;

    assign opcode = instr_id_i[6:0];
    assign rd     = instr_id_i[7 +: RW];
    assign rs1    = instr_id_i[15 +: RW];
    assign rs2    = instr_id_i[20 +: RW];

    reg_file_bp #(
        .XLEN    (XLEN),
        .REG_NUM (REG_NUM)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we       (RegWrite_id_i),
        .wr_addr  (Wr_rd_id_i),
        .wr_data  (Wr_reg_data_id_i),
        .rd_addr1 (rs1),
        .rd_addr2 (rs2),
        .rd_data1 (rs1_data),
        .rd_data2 (rs2_data)
    );

    always_comb begin
        imm_sel = IMM_NONE;
        case (opcode)
            LOAD, OP_IMM, JALR: imm_sel = IMM_I;
            STORE:              imm_sel = IMM_S;
            BRANCH:             imm_sel = IMM_B;
            LUI, AUIPC:         imm_sel = IMM_U;
            JAL:                imm_sel = IMM_J;
            default:            imm_sel = IMM_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_sel)
            IMM_I: imm = {{(XLEN-11){instr_id_i[31]}}, instr_id_i[30:20]};
            IMM_S: imm = {{(XLEN-11){instr_id_i[31]}}, instr_id_i[30:25], instr_id_i[11:7]};
            IMM_B: imm = {{(XLEN-12){instr_id_i[31]}}, instr_id_i[7], instr_id_i[30:25],
                          instr_id_i[11:8], 1'b0};
            IMM_U: imm = {{(XLEN-31){instr_id_i[31]}}, instr_id_i[30:12], 12'b0};
            IMM_J: imm = {{(XLEN-20){instr_id_i[31]}}, instr_id_i[19:12], instr_id_i[20],
                          instr_id_i[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign rs1_used  = !(opcode inside {LUI, AUIPC, JAL});
    assign rs2_used  = opcode inside {OP, STORE, BRANCH};
    assign mem_read  = (opcode == LOAD);
    assign reg_write = (rd != '0) && (opcode inside {OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR});

    // Reset masks the hazard so a stall pending across reset cannot leak into stall_o.
    assign hazard = (HAZ_EN != 0) && !rst && valid_ex_o && mem_read_ex_o && (Rd_ex_o != '0)
                    && instr_valid_i
                    && ((rs1_used && (rs1 == Rd_ex_o)) || (rs2_used && (rs2 == Rd_ex_o)));

    assign stall_o = !flush_i && (ex_stall_i || hazard);

    // ---- ID/EX boundary ----
    always_ff @(posedge clk) begin
        if (rst || (!flush_i && !ex_stall_i && hazard)) begin
            valid_ex_o     <= 1'b0;
            pc_ex_o        <= '0;
            opcode_ex_o    <= '0;
            func3_ex_o     <= '0;
            func7_ex_o     <= 1'b0;
            imme_ex_o      <= '0;
            Rd_data1_ex_o  <= '0;
            Rd_data2_ex_o  <= '0;
            Rs1_ex_o       <= '0;
            Rs2_ex_o       <= '0;
            Rd_ex_o        <= '0;
            mem_read_ex_o  <= 1'b0;
            reg_write_ex_o <= 1'b0;
        end else if (flush_i) begin
            valid_ex_o     <= 1'b0;
            mem_read_ex_o  <= 1'b0;
            reg_write_ex_o <= 1'b0;
        end else if (!ex_stall_i) begin
            valid_ex_o     <= instr_valid_i;
            pc_ex_o        <= pc_id_i;
            opcode_ex_o    <= opcode;
            func3_ex_o     <= instr_id_i[14:12];
            func7_ex_o     <= instr_id_i[30];
            imme_ex_o      <= imm;
            Rd_data1_ex_o  <= rs1_data;
            Rd_data2_ex_o  <= rs2_data;
            Rs1_ex_o       <= rs1;
            Rs2_ex_o       <= rs2;
            Rd_ex_o        <= rd;
            mem_read_ex_o  <= instr_valid_i && mem_read;
            reg_write_ex_o <= instr_valid_i && reg_write;
        end
    end

endmodule
